// File: rtl/vol_meter_if.sv
// vol_meter_if: sample stream, display controls and meter outputs of vol_meter
interface vol_meter_if #(
    parameter int SAMPLE_W = 8,
    parameter int NUM_LEDS = 8
);
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       dot_mode;
    logic                       peak_en;
    logic [SAMPLE_W-2:0]        level;
    logic                       level_valid;
    logic [NUM_LEDS-1:0]        led_level;
    logic                       led_heartbeat;

    modport master (
        output sample_valid, sample, dot_mode, peak_en,
        input  level, level_valid, led_level, led_heartbeat
    );

    modport slave (
        input  sample_valid, sample, dot_mode, peak_en,
        output level, level_valid, led_level, led_heartbeat
    );
endinterface

// File: rtl/vol_meter.sv
// vol_meter: averages sample magnitude over a 2^AVG_LOG2 window and drives an
// LED bar/dot display with peak hold, plus a sample-count heartbeat LED.
module vol_meter #(
    parameter int SAMPLE_W          = 8,
    parameter int AVG_LOG2          = 8,
    parameter int NUM_LEDS          = 8,
    parameter int PEAK_HOLD_WINDOWS = 4,
    parameter int HB_SAMPLES        = 22000
) (
    input logic        clk,
    input logic        reset_n,
    vol_meter_if.slave bus
);
    localparam int MAG_W  = SAMPLE_W - 1;
    localparam int ACC_W  = MAG_W + AVG_LOG2;
    localparam int STEP   = (2 ** MAG_W) / NUM_LEDS;
    localparam int HOLD_W = $clog2(PEAK_HOLD_WINDOWS + 1);
    localparam int HB_W   = $clog2(HB_SAMPLES + 1);

    logic [MAG_W-1:0]    r_mag;
    logic                r_mag_vld;
    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [MAG_W-1:0]    r_level;
    logic [MAG_W-1:0]    r_peak;
    logic                r_level_valid;
    logic [HOLD_W-1:0]   r_hold;
    logic [HB_W-1:0]     r_hb_cnt;
    logic                r_hb;
    logic [NUM_LEDS-1:0] r_led;

    logic [SAMPLE_W-1:0] w_neg;
    logic [MAG_W-1:0]    w_abs;
    logic [ACC_W-1:0]    w_sum;
    logic [MAG_W-1:0]    w_avg;
    logic [NUM_LEDS-1:0] w_lvl_th;
    logic [NUM_LEDS-1:0] w_pk_th;
    logic [NUM_LEDS-1:0] w_lvl_dot;
    logic [NUM_LEDS-1:0] w_pk_dot;

    // The most negative sample negates to itself; its set top bit selects saturation
    assign w_neg = -bus.sample;
    assign w_abs = !bus.sample[SAMPLE_W-1] ? bus.sample[MAG_W-1:0] :
                   w_neg[SAMPLE_W-1]       ? {MAG_W{1'b1}} : w_neg[MAG_W-1:0];
    assign w_sum = r_acc + ACC_W'(r_mag);
    assign w_avg = w_sum[ACC_W-1:AVG_LOG2];

    // Thermometer codes: LED i lights when the value exceeds i*STEP
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_th
        assign w_lvl_th[i] = r_level > MAG_W'(i * STEP);
        assign w_pk_th[i]  = r_peak > MAG_W'(i * STEP);
    end
    assign w_lvl_dot = w_lvl_th & ~(w_lvl_th >> 1);
    assign w_pk_dot  = w_pk_th & ~(w_pk_th >> 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mag     <= '0;
            r_mag_vld <= 1'b0;
        end else begin
            r_mag_vld <= bus.sample_valid;
            if (bus.sample_valid) r_mag <= w_abs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_level       <= '0;
            r_level_valid <= 1'b0;
            r_peak        <= '0;
            r_hold        <= '0;
        end else begin
            r_level_valid <= 1'b0;
            if (r_mag_vld) begin
                r_cnt <= r_cnt + 1'b1;
                if (&r_cnt) begin
                    r_acc         <= '0;
                    r_level       <= w_avg;
                    r_level_valid <= 1'b1;
                    if (w_avg >= r_peak || r_hold == HOLD_W'(PEAK_HOLD_WINDOWS - 1)) begin
                        r_peak <= w_avg;
                        r_hold <= '0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_led <= '0;
        else          r_led <= (bus.dot_mode ? w_lvl_dot : w_lvl_th) | (bus.peak_en ? w_pk_dot : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (bus.sample_valid) begin
            if (r_hb_cnt == HB_W'(HB_SAMPLES - 1)) begin
                r_hb_cnt <= '0;
                r_hb     <= ~r_hb;
            end else begin
                r_hb_cnt <= r_hb_cnt + 1'b1;
            end
        end
    end

    assign bus.level         = r_level;
    assign bus.level_valid   = r_level_valid;
    assign bus.led_level     = r_led;
    assign bus.led_heartbeat = r_hb;
endmodule
